// File: rtl/mem_req_ctrl.sv
// Memory-stage request controller: issues one load/store at a time to mem_system and
// stalls the pipeline until completion. Optional perf counters under MEM_REQ_PERF_EN.
module mem_req_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  input  logic        mem_stall,
  input  logic        mem_hit,
  input  logic        mem_err,
  output logic        stall_pipe,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
`ifdef MEM_REQ_PERF_EN
  output logic [15:0] perf_hits,
  output logic [15:0] perf_misses,
  output logic [15:0] perf_stall_cycles,
`endif
  output logic        err_out
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp, StErr} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [15:0]     addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic            rd_q, rd_d, wr_q, wr_d, resp_q, resp_d, err_q, err_d;

  // Completion is judged only by mem_done; mem_stall is informational.
  logic unused_stall;
  assign unused_stall = mem_stall ^ mem_hit;

  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    resp_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_addr[0]) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            rd_d    = ~req_wr;
            wr_d    = req_wr;
            cnt_d   = '0;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_inc;
        // An error reported alongside Done still aborts the transaction.
        if (mem_err || (!mem_done && cnt_inc == CntW'(TIMEOUT))) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          state_d = StErr;
        end else if (mem_done) begin
          if (rd_q) rdata_d = mem_rdata;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          cnt_d   = '0;
          resp_d  = 1'b1;
          state_d = StResp;
        end
      end
      StResp: state_d = StIdle;
      StErr:  state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_rd     = rd_q;
  assign mem_wr     = wr_q;
  assign resp_valid = resp_q;
  assign resp_rdata = rdata_q;
  assign err_out    = err_q;
  assign stall_pipe = (state_q == StIdle && req_valid) || state_q == StBusy || state_q == StErr;

`ifdef MEM_REQ_PERF_EN
  logic [15:0] hits_q, misses_q, stalls_q;
  logic        done_seen;

  assign done_seen = (state_q == StBusy) && mem_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
      stalls_q <= '0;
    end else begin
      if (done_seen && mem_hit && hits_q != 16'hFFFF) hits_q <= hits_q + 16'd1;
      if (done_seen && !mem_hit && misses_q != 16'hFFFF) misses_q <= misses_q + 16'd1;
      if (stall_pipe && stalls_q != 16'hFFFF) stalls_q <= stalls_q + 16'd1;
    end
  end

  assign perf_hits         = hits_q;
  assign perf_misses       = misses_q;
  assign perf_stall_cycles = stalls_q;
`endif

endmodule
